// File: rtl/frame_egress_process_if.sv
// Egress port bundle: output-queue cell head in, transmit byte/pointer FIFO writes out.
interface frame_egress_process_if;
    logic [127:0] cell_data;
    logic         cell_first;
    logic         cell_valid;
    logic         cell_rd;
    logic         tx_bp;
    logic [7:0]   tx_data;
    logic         tx_data_wr;
    logic [15:0]  tx_ptr_din;
    logic         tx_ptr_wr;
    logic [15:0]  drop_cnt;

    modport master (
        output cell_data, cell_first, cell_valid, tx_bp,
        input  cell_rd, tx_data, tx_data_wr, tx_ptr_din, tx_ptr_wr, drop_cnt
    );
    modport slave (
        input  cell_data, cell_first, cell_valid, tx_bp,
        output cell_rd, tx_data, tx_data_wr, tx_ptr_din, tx_ptr_wr, drop_cnt
    );
endinterface

// File: rtl/frame_egress_process.sv
// Per-port egress reassembler: strips the 2-byte cell header, serialises frame bytes
// one per cycle into the tx byte FIFO and closes each frame with a length word.
module frame_egress_process (
    input  logic                  clk,
    input  logic                  rst,
    frame_egress_process_if.slave bus
);
    typedef enum logic [1:0] {IDLE, DATA, PTR} state_t;
    localparam logic [4:0] CELL_END = 5'd16;

    state_t       state, state_nxt;
    logic [127:0] sbuf, sbuf_nxt;
    logic [4:0]   cidx, cidx_nxt;
    logic [10:0]  flen, flen_nxt;
    logic [10:0]  fidx, fidx_nxt;
    logic [7:0]   data_q, data_nxt;
    logic         data_wr_q, data_wr_nxt;
    logic [15:0]  ptr_q, ptr_nxt;
    logic         ptr_wr_q, ptr_wr_nxt;
    logic [15:0]  drop_q, drop_nxt;
    logic         pop;
    logic [10:0]  hdr_len;

    assign hdr_len = {bus.cell_data[126:124], bus.cell_data[119:112]};

    // Outputs are registered, so each cycle decides the byte/pointer seen next cycle.
    // cidx/fidx therefore index the next byte to emit, one ahead of the outputs.
    always_comb begin
        state_nxt   = state;
        sbuf_nxt    = sbuf;
        cidx_nxt    = cidx;
        flen_nxt    = flen;
        fidx_nxt    = fidx;
        data_nxt    = 8'h00;
        data_wr_nxt = 1'b0;
        ptr_nxt     = 16'h0000;
        ptr_wr_nxt  = 1'b0;
        drop_nxt    = drop_q;
        pop         = 1'b0;
        case (state)
            IDLE: begin
                if (bus.cell_valid && !bus.tx_bp) begin
                    pop = 1'b1;
                    if (!bus.cell_first || hdr_len < 11'd3) begin
                        drop_nxt = (drop_q == 16'hFFFF) ? drop_q : drop_q + 16'd1;
                    end else begin
                        data_nxt    = bus.cell_data[111:104];
                        data_wr_nxt = 1'b1;
                        sbuf_nxt    = bus.cell_data << 24;
                        cidx_nxt    = 5'd3;
                        fidx_nxt    = 11'd3;
                        flen_nxt    = hdr_len;
                        state_nxt   = DATA;
                    end
                end
            end
            DATA: begin
                if (fidx == flen) begin
                    ptr_nxt    = {5'b0, flen - 11'd2};
                    ptr_wr_nxt = 1'b1;
                    state_nxt  = PTR;
                end else if (cidx != CELL_END) begin
                    data_nxt    = sbuf[127:120];
                    data_wr_nxt = 1'b1;
                    sbuf_nxt    = sbuf << 8;
                    cidx_nxt    = cidx + 5'd1;
                    fidx_nxt    = fidx + 11'd1;
                end else if (bus.cell_valid && !bus.cell_first) begin
                    // continuation cell captured and its byte 0 emitted in the same cycle
                    pop         = 1'b1;
                    data_nxt    = bus.cell_data[127:120];
                    data_wr_nxt = 1'b1;
                    sbuf_nxt    = bus.cell_data << 8;
                    cidx_nxt    = 5'd1;
                    fidx_nxt    = fidx + 11'd1;
                end else if (bus.cell_valid) begin
                    // a new frame's head cell arrived early: close this one as truncated
                    ptr_nxt    = {1'b1, 4'b0, fidx - 11'd2};
                    ptr_wr_nxt = 1'b1;
                    state_nxt  = IDLE;
                end
            end
            PTR:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            sbuf      <= '0;
            cidx      <= '0;
            flen      <= '0;
            fidx      <= '0;
            data_q    <= '0;
            data_wr_q <= 1'b0;
            ptr_q     <= '0;
            ptr_wr_q  <= 1'b0;
            drop_q    <= '0;
        end else begin
            state     <= state_nxt;
            sbuf      <= sbuf_nxt;
            cidx      <= cidx_nxt;
            flen      <= flen_nxt;
            fidx      <= fidx_nxt;
            data_q    <= data_nxt;
            data_wr_q <= data_wr_nxt;
            ptr_q     <= ptr_nxt;
            ptr_wr_q  <= ptr_wr_nxt;
            drop_q    <= drop_nxt;
        end
    end

    assign bus.cell_rd    = pop & ~rst;
    assign bus.tx_data    = data_q;
    assign bus.tx_data_wr = data_wr_q;
    assign bus.tx_ptr_din = ptr_q;
    assign bus.tx_ptr_wr  = ptr_wr_q;
    assign bus.drop_cnt   = drop_q;
endmodule

// File: tb/tb_frame_egress_process.sv
// Bench for frame_egress_process: directed table, hand corner cases, and a random
// cell stream checked against a frame-level reference model.
module tb_frame_egress_process;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    frame_egress_process_if bus();
    frame_egress_process dut (.clk(clk), .rst(rst), .bus(bus));

    typedef struct {
        logic [127:0] data;
        logic         first;
    } cell_t;

    typedef struct {
        int          L;
        logic [3:0]  pm;
        logic        first;
        int          exp_wr;
        int          exp_nptr;
        logic [15:0] exp_ptr;
        logic [15:0] exp_dcnt;
        int          exp_rd;
    } vec_t;

    cell_t       cq[$];
    int          vectors = 0;
    int          miscompares = 0;
    int          cyc = 0;
    logic        bp = 1'b0;
    bit          rnd_gap = 0;
    bit          rnd_bp = 0;
    int          gap_pop = -1;
    int          gap_wait = 0;
    int          gap_len = 0;
    int          rd_log[$];
    int          wr_cyc[$];
    logic [7:0]  wr_dat[$];
    logic [15:0] ptr_dat[$];
    int          ptr_cyc[$];
    logic [7:0]  m_bytes[$];
    logic [15:0] m_ptrs[$];
    int          m_drops;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // bad < 0 means the whole sequence matched
    task automatic chk_seq(input string name, input int bad, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (bad >= 0) begin
            miscompares++;
            $display("FAIL %s: at index %0d got 0x%0h, expected 0x%0h", name, bad, act, exp);
        end
    endtask

    task automatic flag(input string name);
        vectors++;
        miscompares++;
        $display("FAIL %s", name);
    endtask

    task automatic clear_logs();
        rd_log.delete(); wr_cyc.delete(); wr_dat.delete(); ptr_dat.delete(); ptr_cyc.delete();
    endtask

    // One clock: drive FIFO head at posedge+1, observe at negedge, pop after the edge.
    task automatic step();
        bit gapped;
        bit popd;
        gapped = 0;
        if (rnd_gap && $urandom_range(0, 4) == 0) gapped = 1;
        if (gap_pop >= 0 && rd_log.size() > gap_pop &&
            cyc - rd_log[gap_pop] >= gap_wait && cyc - rd_log[gap_pop] < gap_wait + gap_len) gapped = 1;
        if (rnd_bp) bp = ($urandom_range(0, 3) == 0);
        bus.tx_bp = bp;
        if (cq.size() > 0 && !gapped) begin
            bus.cell_valid = 1'b1;
            bus.cell_data  = cq[0].data;
            bus.cell_first = cq[0].first;
        end else begin
            bus.cell_valid = 1'b0;
            bus.cell_data  = '0;
            bus.cell_first = 1'b0;
        end
        @(negedge clk);
        popd = bus.cell_rd;
        if (bus.cell_rd) begin
            rd_log.push_back(cyc);
            if (!bus.cell_valid) flag($sformatf("cell_rd without cell_valid at cycle %0d", cyc));
        end
        if (bus.tx_data_wr) begin wr_cyc.push_back(cyc); wr_dat.push_back(bus.tx_data); end
        if (bus.tx_ptr_wr) begin ptr_cyc.push_back(cyc); ptr_dat.push_back(bus.tx_ptr_din); end
        if (bus.tx_data_wr && bus.tx_ptr_wr) flag($sformatf("tx_data_wr and tx_ptr_wr together at cycle %0d", cyc));
        @(posedge clk);
        #1;
        if (popd && cq.size() > 0) cq.delete(0);
        cyc++;
    endtask

    task automatic run_until_drained(input int budget, input string name);
        int n;
        int idle;
        n = 0;
        idle = 0;
        while ((cq.size() > 0 || idle < 24) && n < budget) begin
            if (cq.size() == 0) idle++;
            step();
            n++;
        end
        if (n >= budget) flag($sformatf("%s: timeout after %0d cycles, %0d cells left", name, n, cq.size()));
    endtask

    // Builds a frame as cells: header {0,L[10:8],pm,L[7:0]} then payload base+i (or random).
    task automatic push_frame(input int L, input int nc, input logic [3:0] pm, input logic first, input int base);
        logic [10:0] l11;
        int          need;
        int          n;
        int          p;
        cell_t       x;
        logic [7:0]  b;
        l11  = L[10:0];
        need = (L + 15) / 16;
        if (need < 1) need = 1;
        n = (nc < 0) ? need : nc;
        for (int c = 0; c < n; c++) begin
            x.first = (c == 0) ? first : 1'b0;
            for (int k = 0; k < 16; k++) begin
                p = 16 * c + k;
                if (p == 0)         b = {1'b0, l11[10:8], pm};
                else if (p == 1)    b = l11[7:0];
                else if (base >= 0) b = 8'(base + p - 2);
                else                b = 8'($urandom);
                x.data[127 - 8 * k -: 8] = b;
            end
            cq.push_back(x);
        end
    endtask

    // Frame-level reference: walk the cell list, group cells into frames by header length,
    // cut a frame short when another head cell shows up, drop orphans and runts.
    task automatic model(input cell_t cells[$]);
        int          i;
        int          L;
        int          need;
        int          got;
        bit          trunc;
        logic [10:0] hl;
        logic [7:0]  st[$];
        m_bytes.delete(); m_ptrs.delete(); m_drops = 0;
        i = 0;
        while (i < cells.size()) begin
            hl = {cells[i].data[126:124], cells[i].data[119:112]};
            L  = int'(hl);
            if (!cells[i].first || L < 3) begin
                m_drops++;
                i++;
            end else begin
                need = (L + 15) / 16;
                got = 0;
                trunc = 0;
                st.delete();
                while (got < need && i < cells.size() && !trunc) begin
                    if (got > 0 && cells[i].first) trunc = 1;
                    else begin
                        for (int k = 0; k < 16; k++) st.push_back(cells[i].data[127 - 8 * k -: 8]);
                        got++;
                        i++;
                    end
                end
                if (trunc) begin
                    for (int p = 2; p < st.size(); p++) m_bytes.push_back(st[p]);
                    m_ptrs.push_back(16'h8000 | 16'(st.size() - 2));
                end else begin
                    for (int p = 2; p < L; p++) m_bytes.push_back(st[p]);
                    m_ptrs.push_back(16'(L - 2));
                end
            end
        end
    endtask

    vec_t  vt[9];
    cell_t snap[$];

    initial begin
        int t;
        int bad;
        int n;
        logic [15:0] d0;
        logic [31:0] ba, be;

        rst = 1'b1;
        bus.cell_valid = 1'b0; bus.cell_first = 1'b0; bus.cell_data = '0; bus.tx_bp = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        bus.cell_valid = 1'b1;
        #1;
        chk("reset tx_data", bus.tx_data, 0);
        chk("reset tx_data_wr", bus.tx_data_wr, 0);
        chk("reset tx_ptr_din", bus.tx_ptr_din, 0);
        chk("reset tx_ptr_wr", bus.tx_ptr_wr, 0);
        chk("reset drop_cnt", bus.drop_cnt, 0);
        chk("reset cell_rd", bus.cell_rd, 0);
        bus.cell_valid = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;

        // ---------------- directed table ----------------
        vt[0] = '{12,   4'h5,    1'b0, 0,    0, 16'h0000, 16'd1, 1};
        vt[1] = '{2,    4'h6,    1'b1, 0,    0, 16'h0000, 16'd2, 1};
        vt[2] = '{12,   4'b0100, 1'b1, 10,   1, 16'h000A, 16'd2, 1};
        vt[3] = '{3,    4'h1,    1'b1, 1,    1, 16'h0001, 16'd2, 1};
        vt[4] = '{16,   4'h2,    1'b1, 14,   1, 16'h000E, 16'd2, 1};
        vt[5] = '{17,   4'h3,    1'b1, 15,   1, 16'h000F, 16'd2, 2};
        vt[6] = '{62,   4'h8,    1'b1, 60,   1, 16'h003C, 16'd2, 4};
        vt[7] = '{0,    4'h7,    1'b1, 0,    0, 16'h0000, 16'd3, 1};
        vt[8] = '{2047, 4'hF,    1'b1, 2045, 1, 16'h07FD, 16'd3, 128};
        for (int i = 0; i < 9; i++) begin
            clear_logs();
            push_frame(vt[i].L, -1, vt[i].pm, vt[i].first, 'hA0);
            run_until_drained(vt[i].L + 100, $sformatf("vec%0d", i));
            chk($sformatf("vec%0d write count", i), wr_dat.size(), vt[i].exp_wr);
            chk($sformatf("vec%0d ptr count", i), ptr_dat.size(), vt[i].exp_nptr);
            chk($sformatf("vec%0d cell_rd count", i), rd_log.size(), vt[i].exp_rd);
            chk($sformatf("vec%0d drop_cnt", i), bus.drop_cnt, vt[i].exp_dcnt);
            if (vt[i].exp_nptr > 0 && ptr_dat.size() > 0)
                chk($sformatf("vec%0d tx_ptr_din", i), ptr_dat[0], vt[i].exp_ptr);
            if (vt[i].exp_wr > 0 && wr_dat.size() == vt[i].exp_wr && rd_log.size() > 0 && ptr_cyc.size() > 0) begin
                t = rd_log[0];
                bad = -1; ba = 0; be = 0;
                for (int k = 0; k < wr_dat.size(); k++)
                    if (bad < 0 && wr_dat[k] !== 8'(8'hA0 + k)) begin bad = k; ba = wr_dat[k]; be = 8'(8'hA0 + k); end
                chk_seq($sformatf("vec%0d byte order", i), bad, ba, be);
                bad = -1;
                for (int k = 0; k < wr_cyc.size(); k++)
                    if (bad < 0 && wr_cyc[k] - t != k + 1) begin bad = k; ba = wr_cyc[k] - t; be = k + 1; end
                chk_seq($sformatf("vec%0d write cycle (rel. capture)", i), bad, ba, be);
                chk($sformatf("vec%0d ptr cycle (rel. capture)", i), ptr_cyc[0] - t, vt[i].L - 1);
                bad = -1;
                for (int k = 1; k < rd_log.size(); k++)
                    if (bad < 0 && rd_log[k] - t != 14 + 16 * (k - 1)) begin bad = k; ba = rd_log[k] - t; be = 14 + 16 * (k - 1); end
                if (rd_log.size() > 1) chk_seq($sformatf("vec%0d cell_rd cycle (rel. capture)", i), bad, ba, be);
            end
        end

        // ---------------- 3-cycle valid gap before cell 2 ----------------
        clear_logs();
        push_frame(62, -1, 4'h2, 1'b1, 'h10);
        gap_pop = 0; gap_wait = 14; gap_len = 3;
        run_until_drained(200, "gap");
        gap_pop = -1;
        chk("gap write count", wr_dat.size(), 60);
        if (wr_dat.size() == 60) begin
            bad = -1; ba = 0; be = 0;
            for (int k = 0; k < 60; k++)
                if (bad < 0 && wr_dat[k] !== 8'(8'h10 + k)) begin bad = k; ba = wr_dat[k]; be = 8'(8'h10 + k); end
            chk_seq("gap byte order", bad, ba, be);
            bad = -1;
            for (int k = 1; k < 60; k++)
                if (bad < 0 && wr_cyc[k] - wr_cyc[k - 1] != ((k == 14) ? 4 : 1)) begin
                    bad = k; ba = wr_cyc[k] - wr_cyc[k - 1]; be = (k == 14) ? 4 : 1;
                end
            chk_seq("gap write spacing", bad, ba, be);
        end
        if (ptr_dat.size() > 0) chk("gap tx_ptr_din", ptr_dat[0], 16'h003C);
        else flag("gap: no pointer written");

        // ---------------- truncated frame followed by a new frame ----------------
        clear_logs();
        push_frame(62, 2, 4'h1, 1'b1, 'h20);
        push_frame(12, -1, 4'h4, 1'b1, 'h40);
        run_until_drained(200, "trunc");
        chk("trunc write count", wr_dat.size(), 40);
        chk("trunc cell_rd count", rd_log.size(), 3);
        chk("trunc ptr count", ptr_dat.size(), 2);
        if (ptr_dat.size() == 2) begin
            chk("trunc tx_ptr_din", ptr_dat[0], 16'h801E);
            chk("trunc next frame ptr", ptr_dat[1], 16'h000A);
        end
        if (wr_dat.size() == 40) begin
            bad = -1; ba = 0; be = 0;
            for (int k = 0; k < 40; k++) begin
                logic [7:0] e;
                e = (k < 30) ? 8'(8'h20 + k) : 8'(8'h40 + k - 30);
                if (bad < 0 && wr_dat[k] !== e) begin bad = k; ba = wr_dat[k]; be = e; end
            end
            chk_seq("trunc byte order", bad, ba, be);
        end

        // ---------------- backpressure ----------------
        clear_logs();
        push_frame(12, -1, 4'h3, 1'b1, 'h50);
        bp = 1'b1;
        repeat (20) step();
        chk("bp holds cell (cell_rd count)", rd_log.size(), 0);
        bp = 1'b0;
        t = cyc;
        step();
        chk("bp release cell_rd count", rd_log.size(), 1);
        if (rd_log.size() == 1) chk("bp release capture cycle", rd_log[0] - t, 0);
        bp = 1'b1;
        run_until_drained(100, "bp midframe");
        bp = 1'b0;
        chk("bp midframe write count", wr_dat.size(), 10);
        if (ptr_dat.size() > 0) chk("bp midframe tx_ptr_din", ptr_dat[0], 16'h000A);
        else flag("bp midframe: no pointer written");

        // ---------------- reset at mid-frame byte 5 ----------------
        clear_logs();
        push_frame(62, -1, 4'h9, 1'b1, 'h60);
        n = 0;
        while (wr_dat.size() < 5 && n < 40) begin step(); n++; end
        if (wr_dat.size() < 5) flag("midreset: frame never reached byte 5");
        rst = 1'b1;
        #1;
        chk("midreset tx_data", bus.tx_data, 0);
        chk("midreset tx_data_wr", bus.tx_data_wr, 0);
        chk("midreset tx_ptr_din", bus.tx_ptr_din, 0);
        chk("midreset tx_ptr_wr", bus.tx_ptr_wr, 0);
        chk("midreset drop_cnt", bus.drop_cnt, 0);
        chk("midreset ptr before reset", ptr_dat.size(), 0);
        clear_logs();
        repeat (2) step();
        rst = 1'b0;
        run_until_drained(200, "midreset");
        chk("midreset later writes", wr_dat.size(), 0);
        chk("midreset later ptrs", ptr_dat.size(), 0);
        chk("midreset leftover cells popped", rd_log.size(), 3);
        chk("midreset leftover orphans dropped", bus.drop_cnt, 3);

        // ---------------- random stream vs reference model ----------------
        clear_logs();
        for (int it = 0; it < 40; it++) begin
            int r;
            int L;
            r = $urandom_range(0, 9);
            if (r == 0) push_frame($urandom_range(0, 300), 1, 4'($urandom), 1'b0, -1);
            else if (r == 1) push_frame($urandom_range(0, 2), -1, 4'($urandom), 1'b1, -1);
            else if (r == 2) begin
                L = $urandom_range(33, 300);
                push_frame(L, $urandom_range(1, (L + 15) / 16 - 1), 4'($urandom), 1'b1, -1);
            end else push_frame($urandom_range(3, 300), -1, 4'($urandom), 1'b1, -1);
        end
        push_frame($urandom_range(3, 100), -1, 4'hA, 1'b1, -1);
        snap = cq;
        model(snap);
        d0 = bus.drop_cnt;
        rnd_gap = 1; rnd_bp = 1;
        run_until_drained(30000, "random");
        rnd_gap = 0; rnd_bp = 0; bp = 1'b0;
        chk("rand write count", wr_dat.size(), m_bytes.size());
        chk("rand ptr count", ptr_dat.size(), m_ptrs.size());
        chk("rand cell_rd count", rd_log.size(), snap.size());
        chk("rand drops", bus.drop_cnt - d0, m_drops);
        bad = -1; ba = 0; be = 0;
        for (int k = 0; k < wr_dat.size() && k < m_bytes.size(); k++)
            if (bad < 0 && wr_dat[k] !== m_bytes[k]) begin bad = k; ba = wr_dat[k]; be = m_bytes[k]; end
        chk_seq("rand byte stream", bad, ba, be);
        bad = -1;
        for (int k = 0; k < ptr_dat.size() && k < m_ptrs.size(); k++)
            if (bad < 0 && ptr_dat[k] !== m_ptrs[k]) begin bad = k; ba = ptr_dat[k]; be = m_ptrs[k]; end
        chk_seq("rand ptr stream", bad, ba, be);

        // ---------------- drop_cnt saturation ----------------
        rst = 1'b1;
        #2;
        rst = 1'b0;
        bus.tx_bp = 1'b0; bus.cell_valid = 1'b1; bus.cell_first = 1'b0; bus.cell_data = '0;
        repeat (100) @(posedge clk);
        #1;
        chk("drop_cnt counting", bus.drop_cnt, 100);
        repeat (65440) @(posedge clk);
        #1;
        chk("drop_cnt saturation", bus.drop_cnt, 16'hFFFF);
        bus.cell_valid = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
